// File: rtl/keypad_digit_loader.sv
// Keypad front end for the microwave timer: debounces digit/start/stop keys,
// shifts BCD digits into the counter and sequences run, pause and cancel.
module keypad_digit_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic [9:0] digit_keys,
  input  logic       start_key,
  input  logic       stop_key,
  input  logic       timer_done,
  output logic [3:0] data,
  output logic       load_strobe,
  output logic       loadn,
  output logic       enable,
  output logic       counter_clearn,
  output logic [1:0] digit_count
);

  localparam int            CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_CYCLES);
  localparam logic [1:0]    COUNT_MAX  = 2'(MAX_DIGITS);
  localparam logic [3:0]    CODE_START = 4'd10;
  localparam logic [3:0]    CODE_STOP  = 4'd11;
  localparam logic [3:0]    CODE_NONE  = 4'd15;

  typedef enum logic [2:0] {IDLE, PRESENT, STROBE, HOLD, RUN, PAUSE} state_t;

  logic [11:0]   key_lines;
  logic [3:0]    hit_count;
  logic [3:0]    code_enc, code_q, code_prev;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          reach, armed, accept;
  logic          is_digit, is_start, is_stop;

  state_t        state_q, state_d;
  logic [3:0]    data_d;
  logic          strobe_d, loadn_d, enable_d, clearn_d;
  logic [1:0]    count_d, count_inc;

  assign key_lines = {stop_key, start_key, digit_keys};

  // Multiple simultaneous keys collapse to NONE so they can never be accepted.
  always_comb begin
    hit_count = '0;
    code_enc  = CODE_NONE;
    for (int i = 0; i < 12; i++) begin
      if (key_lines[i]) begin
        hit_count = hit_count + 4'd1;
        code_enc  = 4'(i);
      end
    end
    if (hit_count != 4'd1) code_enc = CODE_NONE;
  end

  always_comb begin
    if (code_q != code_prev)   cnt_d = CW'(1);
    else if (cnt_q == DEB_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CW'(1);
  end

  // reach fires only on the cycle the run length first hits DEBOUNCE_CYCLES.
  assign reach    = (cnt_d == DEB_MAX) && ((code_q != code_prev) || (cnt_q != DEB_MAX));
  assign accept   = reach && armed && (code_q != CODE_NONE);
  assign is_digit = accept && (code_q <= 4'd9);
  assign is_start = accept && (code_q == CODE_START);
  assign is_stop  = accept && (code_q == CODE_STOP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      code_q    <= CODE_NONE;
      code_prev <= CODE_NONE;
      cnt_q     <= '0;
      armed     <= 1'b1;
    end else begin
      code_q    <= code_enc;
      code_prev <= code_q;
      cnt_q     <= cnt_d;
      if (reach) armed <= (code_q == CODE_NONE);
    end
  end

  assign count_inc = (digit_count >= COUNT_MAX) ? digit_count : digit_count + 2'd1;

  // NOTE: every signal gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    data_d   = data;
    strobe_d = 1'b0;
    loadn_d  = loadn;
    enable_d = enable;
    clearn_d = 1'b1;
    count_d  = digit_count;
    unique case (state_q)
      IDLE: begin
        loadn_d  = 1'b0;
        enable_d = 1'b0;
        if (is_digit) begin
          data_d  = code_q;
          state_d = PRESENT;
        end else if (is_start && digit_count != 2'd0) begin
          loadn_d  = 1'b1;
          enable_d = 1'b1;
          state_d  = RUN;
        end else if (is_stop) begin
          clearn_d = 1'b0;
          count_d  = '0;
        end
      end
      PRESENT: begin
        strobe_d = 1'b1;
        count_d  = count_inc;
        state_d  = STROBE;
      end
      STROBE: state_d = HOLD;
      HOLD:   state_d = IDLE;
      RUN: begin
        if (timer_done) begin
          loadn_d  = 1'b0;
          enable_d = 1'b0;
          count_d  = '0;
          state_d  = IDLE;
        end else if (is_stop) begin
          enable_d = 1'b0;
          state_d  = PAUSE;
        end
      end
      PAUSE: begin
        if (is_start) begin
          enable_d = 1'b1;
          state_d  = RUN;
        end else if (is_stop) begin
          clearn_d = 1'b0;
          loadn_d  = 1'b0;
          count_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      state_q        <= IDLE;
      data           <= '0;
      load_strobe    <= 1'b0;
      loadn          <= 1'b0;
      enable         <= 1'b0;
      counter_clearn <= 1'b1;
      digit_count    <= '0;
    end else begin
      state_q        <= state_d;
      data           <= data_d;
      load_strobe    <= strobe_d;
      loadn          <= loadn_d;
      enable         <= enable_d;
      counter_clearn <= clearn_d;
      digit_count    <= count_d;
    end
  end

endmodule

// File: tb/tb_keypad_digit_loader.sv
// Bench for keypad_digit_loader: run-length keypad model checked every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_keypad_digit_loader;

  localparam int DEB       = 4;
  localparam int MAXD      = 3;
  localparam int NONE_CODE = 15;

  logic       CLK = 1'b0;
  logic       clear;
  logic [9:0] digit_keys;
  logic       start_key, stop_key, timer_done;
  logic [3:0] data;
  logic       load_strobe, loadn, enable, counter_clearn;
  logic [1:0] digit_count;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_digit_loader #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(MAXD)) dut (
    .CLK            (CLK),
    .clear          (clear),
    .digit_keys     (digit_keys),
    .start_key      (start_key),
    .stop_key       (stop_key),
    .timer_done     (timer_done),
    .data           (data),
    .load_strobe    (load_strobe),
    .loadn          (loadn),
    .enable         (enable),
    .counter_clearn (counter_clearn),
    .digit_count    (digit_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a key is accepted when its run of identical samples
  // reaches DEB; a load takes three cycles with the strobe in the middle one.
  int m_data, m_strobe, m_loadn, m_enable, m_clearn, m_count;
  int load_t, run_len, last_code, code, ev_code;
  bit armed, ev;

  function automatic int encode_keys();
    logic [11:0] lines;
    lines = {stop_key, start_key, digit_keys};
    if ($countones(lines) != 1) return NONE_CODE;
    for (int i = 0; i < 12; i++) if (lines[i]) return i;
    return NONE_CODE;
  endfunction

  always @(posedge CLK or posedge clear) begin
    if (clear) begin
      m_data = 0; m_strobe = 0; m_loadn = 0; m_enable = 0; m_clearn = 1; m_count = 0;
      load_t = 0; armed = 1; last_code = NONE_CODE; run_len = 1;
    end else begin
      ev = 0;
      ev_code = last_code;
      if (run_len == DEB) begin
        if (last_code == NONE_CODE) armed = 1;
        else if (armed) begin ev = 1; armed = 0; end
      end
      m_strobe = 0;
      m_clearn = 1;
      if (load_t != 0) begin
        load_t = (load_t == 3) ? 0 : load_t + 1;
        if (load_t == 2) begin
          m_strobe = 1;
          if (m_count < MAXD) m_count++;
        end
      end else if (m_loadn == 0) begin
        if (ev && ev_code <= 9) begin m_data = ev_code; load_t = 1; end
        else if (ev && ev_code == 10 && m_count > 0) begin m_loadn = 1; m_enable = 1; end
        else if (ev && ev_code == 11) begin m_clearn = 0; m_count = 0; end
      end else if (m_enable == 1) begin
        if (timer_done) begin m_loadn = 0; m_enable = 0; m_count = 0; end
        else if (ev && ev_code == 11) m_enable = 0;
      end else begin
        if (ev && ev_code == 10) m_enable = 1;
        else if (ev && ev_code == 11) begin m_clearn = 0; m_loadn = 0; m_count = 0; end
      end
      code = encode_keys();
      if (code == last_code) run_len++;
      else begin last_code = code; run_len = 1; end
    end
  end

  always @(negedge CLK) begin
    if (clear === 1'b0) begin
      check("data", data, m_data);
      check("load_strobe", load_strobe, m_strobe);
      check("loadn", loadn, m_loadn);
      check("enable", enable, m_enable);
      check("counter_clearn", counter_clearn, m_clearn);
      check("digit_count", digit_count, m_count);
    end
  end

  int         strobe_total = 0;
  int         clearn_low_total = 0;
  logic [3:0] last_strobe_data = '0;

  always @(negedge CLK) begin
    if (load_strobe === 1'b1) begin
      strobe_total++;
      last_strobe_data = data;
    end
    if (counter_clearn === 1'b0) clearn_low_total++;
  end

  task automatic drive_code(input int c);
    digit_keys = '0;
    start_key  = 1'b0;
    stop_key   = 1'b0;
    if (c < 10) digit_keys[c] = 1'b1;
    else if (c == 10) start_key = 1'b1;
    else if (c == 11) stop_key = 1'b1;
  endtask

  task automatic press(input int c, input int hold, input int rel);
    drive_code(c);
    repeat (hold) @(negedge CLK);
    drive_code(NONE_CODE);
    repeat (rel) @(negedge CLK);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int base, got, sel, hold, rel;

  initial begin
    clear = 1'b1;
    timer_done = 1'b0;
    drive_code(NONE_CODE);
    repeat (3) @(negedge CLK);
    check("rst_data", data, 0);
    check("rst_strobe", load_strobe, 0);
    check("rst_loadn", loadn, 0);
    check("rst_enable", enable, 0);
    check("rst_clearn", counter_clearn, 1);
    check("rst_count", digit_count, 0);
    clear = 1'b0;
    repeat (6) @(negedge CLK);

    base = strobe_total;
    press(2, 6, 6); press(1, 6, 6); press(7, 6, 6);
    check("three_strobes", strobe_total - base, 3);
    check("count_after_217", digit_count, 3);
    check("data_after_217", data, 7);
    check("loadn_entry", loadn, 0);

    base = strobe_total;
    press(9, 6, 6);
    check("fourth_strobe", strobe_total - base, 1);
    check("fourth_data", last_strobe_data, 9);
    check("count_saturated", digit_count, 3);

    drive_code(10);
    got = 0;
    for (int i = 0; i <= DEB; i++) begin
      @(negedge CLK);
      if (loadn === 1'b1 && enable === 1'b1) begin got = 1; break; end
    end
    check("start_latency", got, 1);
    drive_code(NONE_CODE);
    repeat (8) @(negedge CLK);
    timer_done = 1'b1;
    @(negedge CLK);
    timer_done = 1'b0;
    check("done_loadn", loadn, 0);
    check("done_enable", enable, 0);
    check("done_count", digit_count, 0);

    base = strobe_total;
    for (int i = 0; i < 3; i++) begin
      drive_code(5); repeat (2) @(negedge CLK);
      drive_code(NONE_CODE); repeat (2) @(negedge CLK);
    end
    press(5, 10, 8);
    check("bounce_one_strobe", strobe_total - base, 1);
    check("bounce_data", last_strobe_data, 5);
    base = strobe_total;
    digit_keys = 10'b0000011000;
    repeat (8) @(negedge CLK);
    drive_code(NONE_CODE);
    repeat (8) @(negedge CLK);
    check("two_keys_no_strobe", strobe_total - base, 0);

    press(11, 6, 6);
    check("idle_stop_count", digit_count, 0);
    press(1, 6, 6); press(3, 6, 6); press(0, 6, 6);
    check("count_130", digit_count, 3);
    press(10, 6, 6);
    check("run_enable", enable, 1);
    check("run_loadn", loadn, 1);
    press(11, 6, 6);
    check("pause_enable", enable, 0);
    check("pause_loadn", loadn, 1);
    press(10, 6, 6);
    check("resume_enable", enable, 1);
    press(11, 6, 6);
    base = clearn_low_total;
    press(11, 6, 6);
    check("cancel_clearn_pulse", clearn_low_total - base, 1);
    check("cancel_loadn", loadn, 0);
    check("cancel_count", digit_count, 0);

    press(10, 6, 6);
    check("start_empty_loadn", loadn, 0);
    check("start_empty_enable", enable, 0);
    base = strobe_total;
    press(8, 50, 8);
    check("long_hold_one_strobe", strobe_total - base, 1);

    drive_code(6);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (load_strobe === 1'b1) begin got = 1; break; end
    end
    check("strobe_seen", got, 1);
    #1 clear = 1'b1;
    #1;
    check("clr_strobe", load_strobe, 0);
    check("clr_data", data, 0);
    check("clr_count", digit_count, 0);
    drive_code(NONE_CODE);
    @(negedge CLK);
    clear = 1'b0;
    repeat (4) @(negedge CLK);
    base = strobe_total;
    press(4, 6, 6);
    check("after_clr_strobe", strobe_total - base, 1);
    check("after_clr_data", last_strobe_data, 4);
    check("after_clr_count", digit_count, 1);

    for (int it = 0; it < 300; it++) begin
      sel  = $urandom_range(0, 15);
      hold = $urandom_range(1, 9);
      rel  = $urandom_range(1, 9);
      if (sel <= 11) drive_code(sel);
      else if (sel == 12) digit_keys = 10'($urandom) | 10'b0000000011;
      else drive_code(NONE_CODE);
      timer_done = ($urandom_range(0, 9) == 0);
      repeat (hold) @(negedge CLK);
      timer_done = 1'b0;
      drive_code(NONE_CODE);
      if ($urandom_range(0, 49) == 0) begin
        #2 clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
      end
      repeat (rel) @(negedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
